// File: rtl/md_pkg.sv
// Shared definitions for the HI/LO multiply/divide scheduler: op codes, FSM encoding,
// divide-by-zero quotient and a magnitude helper.
package md_pkg;

    localparam logic [3:0] MD_MULT  = 4'd0;
    localparam logic [3:0] MD_MULTU = 4'd1;
    localparam logic [3:0] MD_DIV   = 4'd2;
    localparam logic [3:0] MD_DIVU  = 4'd3;
    localparam logic [3:0] MD_MTHI  = 4'd4;
    localparam logic [3:0] MD_MTLO  = 4'd5;
    localparam logic [3:0] MD_MADD  = 4'd6;
    localparam logic [3:0] MD_MADDU = 4'd7;

    localparam logic [31:0] DIV0_LO = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2
    } md_state_t;

    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? -v : v;
    endfunction

endpackage

// File: rtl/md_div_step.sv
// One combinational restoring radix-2 divide step: shift in the next dividend bit,
// trial-subtract the divisor, and shift the resulting quotient bit into the shift reg.
module md_div_step (
    input  logic [31:0] rem,
    input  logic [31:0] shq,
    input  logic [31:0] divisor,
    output logic [31:0] rem_nxt,
    output logic [31:0] shq_nxt
);

    logic [32:0] shifted;
    logic [32:0] diff;
    logic        ge;

    always_comb begin
        shifted = {rem, shq[31]};
        diff    = shifted - {1'b0, divisor};
        ge      = !diff[32];
        rem_nxt = ge ? diff[31:0] : shifted[31:0];
        shq_nxt = {shq[30:0], ge};
    end

endmodule

// File: rtl/md_sched.sv
// HI/LO owner: fixed-latency multiply, 32-step restoring divide, MTHI/MTLO.
// Define MD_SCHED_MADD_EN to enable MADD/MADDU accumulate; otherwise they are no-ops.
//
// state | meaning
// IDLE  | accepting Start; MTHI/MTLO write here
// MUL   | product held in stage reg, counting down to commit
// DIV   | one restoring step per cycle, commit on the last
module md_sched
    import md_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_STEPS   = 32
) (
    input  logic        CLK,
    input  logic        Reset_n,
    input  logic        Start,
    input  logic [3:0]  MDOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        Cancel,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_t   state, state_nxt;
    logic [5:0]  cnt, cnt_nxt;
    logic [63:0] prod, prod_new, mul_res;
    logic [63:0] a_ext, b_ext;
    logic [31:0] rem, shq, dvsr, rem_nxt, shq_nxt;
    logic [31:0] q_fix, r_fix, lo_div;
    logic [31:0] hi_r, lo_r;
    logic        neg_q, neg_r, div0, done_r;
    logic        sgn, is_mul, is_div;
    logic        load_mul, load_div, commit, wr_hi, wr_lo;
`ifdef MD_SCHED_MADD_EN
    logic        acc;
`endif

    always_comb begin
        sgn    = (MDOp == MD_MULT) || (MDOp == MD_DIV) || (MDOp == MD_MADD);
        is_div = (MDOp == MD_DIV) || (MDOp == MD_DIVU);
`ifdef MD_SCHED_MADD_EN
        is_mul = (MDOp == MD_MULT) || (MDOp == MD_MULTU) ||
                 (MDOp == MD_MADD) || (MDOp == MD_MADDU);
`else
        is_mul = (MDOp == MD_MULT) || (MDOp == MD_MULTU);
`endif
        a_ext    = sgn ? {{32{A[31]}}, A} : {32'd0, A};
        b_ext    = sgn ? {{32{B[31]}}, B} : {32'd0, B};
        prod_new = a_ext * b_ext;
    end

    md_div_step u_div_step (
        .rem     (rem),
        .shq     (shq),
        .divisor (dvsr),
        .rem_nxt (rem_nxt),
        .shq_nxt (shq_nxt)
    );

    // Divide by zero falls out of the restoring loop with rem = |A|, so only LO needs overriding.
    assign q_fix  = neg_q ? -shq_nxt : shq_nxt;
    assign r_fix  = neg_r ? -rem_nxt : rem_nxt;
    assign lo_div = div0 ? DIV0_LO : q_fix;

`ifdef MD_SCHED_MADD_EN
    assign mul_res = acc ? ({hi_r, lo_r} + prod) : prod;
`else
    assign mul_res = prod;
`endif

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        load_mul  = 1'b0;
        load_div  = 1'b0;
        commit    = 1'b0;
        wr_hi     = 1'b0;
        wr_lo     = 1'b0;
        if (Cancel) begin
            state_nxt = IDLE;
            cnt_nxt   = 6'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start) begin
                        if (is_mul) begin
                            load_mul  = 1'b1;
                            state_nxt = MUL;
                            cnt_nxt   = 6'(MULT_CYCLES - 1);
                        end else if (is_div) begin
                            load_div  = 1'b1;
                            state_nxt = DIV;
                            cnt_nxt   = 6'(DIV_STEPS - 1);
                        end else begin
                            wr_hi = (MDOp == MD_MTHI);
                            wr_lo = (MDOp == MD_MTLO);
                        end
                    end
                end
                MUL, DIV: begin
                    if (cnt == 6'd0) begin
                        commit    = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt - 6'd1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            state <= IDLE;
            cnt   <= 6'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_ff @(posedge CLK) begin
        if (!Reset_n) begin
            prod   <= '0;
            rem    <= '0;
            shq    <= '0;
            dvsr   <= '0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            hi_r   <= '0;
            lo_r   <= '0;
            done_r <= 1'b0;
`ifdef MD_SCHED_MADD_EN
            acc    <= 1'b0;
`endif
        end else begin
            done_r <= commit | wr_hi | wr_lo;
            if (load_mul) begin
                prod <= prod_new;
`ifdef MD_SCHED_MADD_EN
                acc  <= (MDOp == MD_MADD) || (MDOp == MD_MADDU);
`endif
            end
            if (load_div) begin
                rem   <= '0;
                shq   <= sgn ? abs32(A) : A;
                dvsr  <= sgn ? abs32(B) : B;
                neg_q <= sgn & (A[31] ^ B[31]);
                neg_r <= sgn & A[31];
                div0  <= (B == 32'd0);
            end else if (state == DIV) begin
                rem <= rem_nxt;
                shq <= shq_nxt;
            end
            if (commit) begin
                if (state == MUL) begin
                    {hi_r, lo_r} <= mul_res;
                end else begin
                    hi_r <= r_fix;
                    lo_r <= lo_div;
                end
            end
            if (wr_hi) hi_r <= A;
            if (wr_lo) lo_r <= A;
        end
    end

    assign Busy = (state != IDLE);
    assign Done = done_r;
    assign HI   = hi_r;
    assign LO   = lo_r;

endmodule

// File: doc/md_sched.md
# md_sched

Multi-cycle multiply/divide scheduler owning the HI/LO register pair for the 5-stage pipeline. It accepts one operation per request from the EX stage, sequences a fixed-latency multiply or a 32-step iterative divide, and commits results to HI/LO. Busy feeds the hazard controller, which stalls any HI/LO consumer or new MD request. It replaces the ad-hoc HI/LO accumulate currently inline in EX.

## Interface
Parameters:
- MULT_CYCLES, 5, Busy cycles for mult/multu/madd/maddu (≥1)
- DIV_STEPS, 32, divider iteration count (fixed at 32 for 32-bit operands; present for the bench only)

Ports (CLK, Reset_n: one clock; reset is synchronous and active-low):
- CLK  in  1  clock
- Reset_n  in  1  synchronous active-low reset
- Start  in  1  EX-stage MD instruction valid this cycle
- MDOp  in  4  op code (md_pkg: MD_MULT, MD_MULTU, MD_DIV, MD_DIVU, MD_MTHI, MD_MTLO, MD_MADD, MD_MADDU)
- A  in  32  rs operand, post-forwarding
- B  in  32  rt operand, post-forwarding
- Cancel  in  1  flush of the in-flight op and of this cycle's Start
- Busy  out  1  op in flight; stall request to hazard control
- Done  out  1  one-cycle pulse: HI/LO updated this cycle
- HI  out  32  committed HI
- LO  out  32  committed LO

## Operation
- States: IDLE, MUL, DIV. Down-counter cnt[5:0].
- IDLE & Start & !Cancel:
  - MULT/MULTU/MADD/MADDU: latch the 64-bit product (signed or unsigned) into stage regs. Go to MUL, cnt = MULT_CYCLES−1.
  - DIV/DIVU: latch |A|, |B| (or the raw values for DIVU) and the quotient/remainder sign flags. Go to DIV, cnt = 31.
  - MTHI/MTLO: write HI/LO at this edge. Stay IDLE. No Busy. Done = 1 next cycle.
- MUL: cnt decrements each cycle. At cnt == 0, commit to HI/LO and go to IDLE.
  - MULT/MULTU: {HI,LO} = product.
  - MADD/MADDU: {HI,LO} = {HI,LO} + product, 64-bit, wraps mod 2^64.
- DIV: one restoring radix-2 step per cycle (sub-module). On the final step, commit with sign fix:
  - LO = quotient, negated if sign(A)^sign(B) (signed only).
  - HI = remainder, negated if sign(A) (signed only).
  - 0x80000000 / −1 signed gives LO = 0x80000000, HI = 0.
- Divide by zero: LO = 0xFFFFFFFF, HI = A (unsigned and signed), committed at normal latency.
- Start while Busy is ignored. Hazard control guarantees this does not occur; the bench checks it with an assertion.
- Cancel:
  - Any state → IDLE next cycle. Stage regs dropped, HI/LO unchanged, no Done.
  - Cancel together with Start in IDLE: Start discarded, including MTHI/MTLO.
- Reset_n low: state IDLE, cnt 0, HI = LO = 0, Busy = 0, Done = 0, regardless of the op in flight.

## Timing
- Start sampled at edge t.
- Busy = 1 for cycles t+1 … t+N, with N = MULT_CYCLES for multiply and N = 32 for divide.
- HI/LO show new values and Done = 1 in cycle t+N+1. Busy is 0 in that cycle.
- A back-to-back Start is accepted in cycle t+N+1.
- MTHI/MTLO: HI/LO new in cycle t+1, Done in t+1, Busy never asserted.
- Busy is registered, with no combinational path from Start. Hazard control ORs Start into its own stall term.
- HI/LO are registered outputs and change only at commit, MT*, or reset.

## Configuration
- MD_SCHED_MADD_EN defined: MD_MADD/MD_MADDU accumulate as described above.
- Not defined: MD_MADD/MD_MADDU are treated as no-ops. No state change, no Busy, no Done. The 64-bit adder is removed.

## Structure
- md_pkg holds:
  - MDOp localparams
  - state encoding typedef (IDLE/MUL/DIV)
  - DIV0_LO constant (0xFFFFFFFF)
- One sub-module, md_div_step: combinational restoring step.
  - Inputs: partial remainder, dividend shift reg, divisor.
  - Outputs: next remainder, next shift reg.
  - md_sched instantiates it once and iterates it over 32 cycles.

## Test plan
- MULT A=0xFFFFFFFE (−2), B=3, MULT_CYCLES=5 → Busy high 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA, Done pulse.
- MULTU A=0xFFFFFFFF, B=0xFFFFFFFF → HI=0xFFFFFFFE, LO=0x00000001.
- DIV A=−7, B=2 → Busy high 32 cycles; then LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIVU A=100, B=0 → LO=0xFFFFFFFF, HI=100. Separately, DIV 0x80000000 / 0xFFFFFFFF → LO=0x80000000, HI=0.
- MTHI 0x1234 followed next cycle by MADD 2×3 (macro on) → HI=0x1234, LO=6. With the macro off → HI=0x1234, LO unchanged, Busy never high.
- DIV started, then Cancel in cycle 10 → Busy low next cycle, HI/LO unchanged, no Done. Repeat with Reset_n low mid-op → HI=LO=0, Busy=0.
